// File: rtl/version_info_pkg.sv
// Shared constants, scan state encoding and the CRC-16/CCITT-FALSE byte step
// used by the version/identification string bank.
package version_info_pkg;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_LENGTH = 2;
    localparam int REG_CRC    = 3;
    localparam int REG_DATA   = 4;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_STORE,
        ST_DONE
    } scan_state_t;

    // One byte of CRC-16/CCITT-FALSE, MSB first, no reflection, no final xor.
    function automatic logic [15:0] crc16_step(input logic [7:0] data, input logic [15:0] crc);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/info_crc_scanner.sv
// Post-reset scan engine: walks every string one byte per cycle, keeps a CRC-16
// per slot and reports scan completion; CRC of the selected slot is muxed out.
module info_crc_scanner
    import version_info_pkg::*;
#(
    parameter int                              NumStrings = 4,
    parameter int                              MaxChars   = 64,
    parameter logic [NumStrings*MaxChars*8-1:0] STRINGS    = '0,
    parameter logic [NumStrings*8-1:0]          LENGTHS    = '0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rescan_i,
    input  logic [7:0]  sel_i,
    output logic [15:0] crc_o,
    output logic        scan_done_o
);

    localparam int              SLOT_W = MaxChars * 8;
    localparam int              SW     = (NumStrings > 1) ? $clog2(NumStrings) : 1;
    localparam logic [SW-1:0]   LAST_S = SW'(NumStrings - 1);
    localparam logic [8:0]      NUM_S  = 9'(NumStrings);
    localparam logic [7:0]      LEN0   = LENGTHS[7:0];

    scan_state_t       state;
    logic [SW-1:0]     scan_s;
    logic [7:0]        byte_idx;
    logic [15:0]       crc_acc;
    logic [15:0]       crc_mem [NumStrings];

    logic [SLOT_W-1:0] cur_slot;
    logic [7:0]        cur_len;
    logic [7:0]        next_len;
    logic [7:0]        cur_byte;

    // NOTE: every signal gets a value before any condition, so no latch is inferred.
    always_comb begin
        cur_slot = SLOT_W'(STRINGS >> (32'(scan_s) * SLOT_W));
        cur_len  = 8'(LENGTHS >> (32'(scan_s) * 8));
        next_len = 8'(LENGTHS >> ((32'(scan_s) + 32'd1) * 8));
        // Chars sit in the low LEN bytes with the first char in the highest of them.
        cur_byte = 8'(cur_slot >> ((32'(cur_len) - 32'(byte_idx) - 32'd1) * 8));
    end

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            scan_s      <= '0;
            byte_idx    <= '0;
            crc_acc     <= CRC_INIT;
            scan_done_o <= 1'b0;
            // NOTE: the CRC file is small and must read back as zero after reset, so it is cleared here.
            for (int i = 0; i < NumStrings; i++) begin
                crc_mem[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    scan_s   <= '0;
                    byte_idx <= '0;
                    crc_acc  <= CRC_INIT;
                    state    <= (LEN0 == 8'd0) ? ST_STORE : ST_SCAN;
                end
                ST_SCAN: begin
                    crc_acc  <= crc16_step(cur_byte, crc_acc);
                    byte_idx <= byte_idx + 8'd1;
                    if (byte_idx == cur_len - 8'd1) begin
                        state <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    crc_mem[scan_s] <= crc_acc;
                    crc_acc         <= CRC_INIT;
                    byte_idx        <= '0;
                    if (scan_s == LAST_S) begin
                        state       <= ST_DONE;
                        scan_done_o <= 1'b1;
                    end else begin
                        // Empty strings skip SCAN entirely and store the init value.
                        scan_s <= scan_s + SW'(1);
                        state  <= (next_len == 8'd0) ? ST_STORE : ST_SCAN;
                    end
                end
                ST_DONE: begin
                    if (rescan_i) begin
                        state       <= ST_IDLE;
                        scan_done_o <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        crc_o = '0;
        if ({1'b0, sel_i} < NUM_S) begin
            crc_o = crc_mem[sel_i[SW-1:0]];
        end
    end

endmodule

// File: rtl/version_info_bank.sv
// Read-only register window exposing several build/identification strings with
// select, length, status and per-string CRC registers.
module version_info_bank
    import version_info_pkg::*;
#(
    parameter int                              BaseAddress     = 0,
    parameter int                              address_width   = 15,
    parameter int                              data_width      = 16,
    parameter int                              Address_Wording = 1,
    parameter int                              NumStrings      = 4,
    parameter int                              MaxChars        = 64,
    parameter logic [NumStrings*MaxChars*8-1:0] STRINGS         = '0,
    parameter logic [NumStrings*8-1:0]          LENGTHS         = '0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] address_i,
    input  logic [data_width-1:0]    data_i,
    input  logic                     rd_wr_i,
    output logic [data_width-1:0]    data_o
);

    localparam int                       CPW        = data_width / 8;
    localparam int                       NUM_CHUNKS = (MaxChars + CPW - 1) / CPW;
    localparam int                       SLOT_W     = MaxChars * 8;
    localparam logic [address_width-1:0] BASE       = address_width'(BaseAddress);
    localparam logic [address_width-1:0] STEP       = address_width'(Address_Wording);
    localparam logic [8:0]               NUM_S      = 9'(NumStrings);

    logic                  hit;
    logic [31:0]           off;
    logic                  ctrl_wr;
    logic                  rescan;
    logic [7:0]            sel_q;
    logic                  sel_err;
    logic [15:0]           crc;
    logic                  scan_done;
    logic [SLOT_W-1:0]     slot_sel;
    logic [7:0]            len_sel;
    logic [31:0]           char_base;
    logic [data_width-1:0] chunk_word;
    logic [data_width-1:0] rd_data;
    logic                  unused_data;

    assign hit         = (address_i >= BASE);
    assign off         = 32'((address_i - BASE) / STEP);
    assign ctrl_wr     = rd_wr_i && hit && (off == REG_CTRL);
    assign rescan      = ctrl_wr && data_i[8];
    assign sel_err     = ({1'b0, sel_q} >= NUM_S);
    assign unused_data = ^data_i[data_width-1:9];

    info_crc_scanner #(
        .NumStrings (NumStrings),
        .MaxChars   (MaxChars),
        .STRINGS    (STRINGS),
        .LENGTHS    (LENGTHS)
    ) u_scanner (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rescan_i    (rescan),
        .sel_i       (sel_q),
        .crc_o       (crc),
        .scan_done_o (scan_done)
    );

    always_comb begin
        slot_sel   = '0;
        len_sel    = '0;
        char_base  = (off - 32'(REG_DATA)) * CPW;
        chunk_word = '0;
        if (!sel_err) begin
            slot_sel = SLOT_W'(STRINGS >> (32'(sel_q) * SLOT_W));
            len_sel  = 8'(LENGTHS >> (32'(sel_q) * 8));
        end
        // First char of the chunk lands in the most significant byte; past LEN reads zero.
        for (int j = 0; j < CPW; j++) begin
            if (char_base + 32'(j) < 32'(len_sel)) begin
                chunk_word[(CPW-1-j)*8 +: 8] =
                    8'(slot_sel >> ((32'(len_sel) - char_base - 32'(j) - 32'd1) * 8));
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (hit && !rd_wr_i) begin
            if (off == REG_CTRL) begin
                rd_data[7:0] = sel_q;
            end else if (off == REG_STATUS) begin
                rd_data[1:0] = {sel_err, scan_done};
            end else if (off == REG_LENGTH) begin
                rd_data[7:0] = len_sel;
            end else if (off == REG_CRC) begin
                rd_data[15:0] = (sel_err || !scan_done) ? 16'h0000 : crc;
            end else if (off >= REG_DATA && off < REG_DATA + NUM_CHUNKS) begin
                rd_data = chunk_word;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_o <= '0;
            sel_q  <= '0;
        end else begin
            if (ctrl_wr) begin
                sel_q <= data_i[7:0];
            end
            data_o <= rd_data;
        end
    end

endmodule
